// File: rtl/mult_seq.sv
// mult_seq: iterative 32x32->64 multiply sequencer driving the 32x8 carry-save MAC slice.
// Issues one Booth-encoded multiplier byte per cycle and folds the slice's carry-save pair back as the accumulator.
module mult_seq #(
   parameter int unsigned NSLICE = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] rm,
   input  logic [31:0] rs,
   input  logic        sgn,
   input  logic        accum,
   input  logic [63:0] acc_in,
   output logic        busy,
   output logic        done,
   output logic [63:0] result,
   output logic [32:0] op1,
   output logic [9:0]  op2,
   output logic        op2_1,
   output logic [1:0]  byte_slice,
   output logic        msb,
   output logic [63:0] acc,
   input  logic [63:0] acc_op1,
   input  logic [63:0] acc_op2
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t             state;
   logic [31:0]        rs_q;
   logic               sgn_q;
   logic [1:0]         k;
   logic [4:0]         chunk_lsb;
   logic signed [31:0] rs_sh_s;
   logic [31:0]        rs_sh_u;
   logic               sgn_rest_eq;
   logic               unsg_rest_zero;
   logic               last_chunk;
   logic               term;
   logic [63:0]        sum;

   assign byte_slice = k;
   assign chunk_lsb  = {k, 3'b000};
   assign sum        = acc_op1 + acc_op2;

   // Booth chunk for the slice: byte k of the latched multiplier, sign-extended to 10 bits when signed
   always_comb begin
      op2   = {(sgn_q ? {2{rs_q[chunk_lsb + 5'd7]}} : 2'b00), rs_q[chunk_lsb +: 8]};
      op2_1 = 1'b0;
      if (k != 2'd0) begin
         op2_1 = rs_q[chunk_lsb - 5'd1];
      end
   end

   // Early exit: the bits above this chunk carry no information beyond its own top bit
   always_comb begin
      rs_sh_s        = $signed(rs_q) >>> ({1'b0, chunk_lsb} + 6'd7);
      rs_sh_u        = rs_q >> ({1'b0, chunk_lsb} + 6'd8);
      sgn_rest_eq    = (rs_sh_s == '0) || (rs_sh_s == '1);
      unsg_rest_zero = (rs_sh_u == '0);
      last_chunk     = (k == 2'(NSLICE - 1));
      term           = last_chunk || (sgn_q ? sgn_rest_eq : unsg_rest_zero);
      msb            = (state == RUN) && term;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
         acc    <= '0;
         op1    <= '0;
         rs_q   <= '0;
         sgn_q  <= 1'b0;
         k      <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  op1   <= {sgn & rm[31], rm};
                  rs_q  <= rs;
                  sgn_q <= sgn;
                  acc   <= accum ? acc_in : '0;
                  k     <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               if (msb) begin
                  result <= sum;
                  done   <= 1'b1;
                  busy   <= 1'b0;
                  acc    <= '0;
                  k      <= '0;
                  state  <= IDLE;
               end else begin
                  acc <= sum;
                  k   <= k + 2'd1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_seq.sv
// tb_mult_seq: drives mult_seq against a behavioural MAC-slice model and a transaction-level reference.
// Directed cases pin literal products and latencies; a random phase covers handshake, lengths and resets.
module tb_mult_seq;

   logic        clk = 1'b0;
   logic        reset, start, sgn, accum;
   logic [31:0] rm, rs;
   logic [63:0] acc_in;
   logic        busy, done, op2_1, msb;
   logic [63:0] result, acc, acc_op1, acc_op2;
   logic [32:0] op1;
   logic [9:0]  op2;
   logic [1:0]  byte_slice;

   int unsigned n_pass = 0;
   int unsigned n_total = 0;
   logic        chk_en = 1'b1;

   mult_seq #(.NSLICE(4)) dut (
      .clk(clk), .reset(reset), .start(start), .rm(rm), .rs(rs), .sgn(sgn),
      .accum(accum), .acc_in(acc_in), .busy(busy), .done(done), .result(result),
      .op1(op1), .op2(op2), .op2_1(op2_1), .byte_slice(byte_slice), .msb(msb),
      .acc(acc), .acc_op1(acc_op1), .acc_op2(acc_op2)
   );

   always #5 clk = ~clk;

   // Slice model: acc + op1 * booth_value(chunk) << 8k, split randomly into a carry-save pair
   logic [63:0]        split = '0;
   logic signed [63:0] s_a, s_v, s_pp;
   logic [63:0]        s_full;
   always @(negedge clk) split <= {$urandom, $urandom};
   always_comb begin
      s_a  = {{31{op1[32]}}, op1};
      s_v  = msb ? {{54{op2[9]}}, op2} : {{56{op2[7]}}, op2[7:0]};
      s_v  = s_v + {63'b0, op2_1};
      s_pp = s_a * s_v;
      s_full  = acc + (s_pp << {byte_slice, 3'b000});
      acc_op1 = split;
      acc_op2 = s_full - split;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [63:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                              input logic s, input logic ac, input logic [63:0] ai);
      logic [63:0] x, y;
      x = s ? {{32{a[31]}}, a} : {32'h0, a};
      y = s ? {{32{b[31]}}, b} : {32'h0, b};
      return x * y + (ac ? ai : 64'h0);
   endfunction

   // Chunks needed: smallest byte count whose range still represents the multiplier
   function automatic int ref_chunks(input logic [31:0] b, input logic s);
      longint v, lim;
      v = s ? longint'($signed(b)) : longint'({32'h0, b});
      for (int k = 0; k < 3; k++) begin
         lim = longint'(1) << (8 * k + (s ? 7 : 8));
         if (s ? (v >= -lim && v < lim) : (v < lim)) return k + 1;
      end
      return 4;
   endfunction

   logic        m_busy = 1'b0, m_done = 1'b0, m_sgn = 1'b0;
   logic [63:0] m_result = '0, m_pending = '0;
   logic [32:0] m_op1 = '0;
   logic [31:0] m_rs = '0;
   int          m_left = 0, m_n = 0;

   always @(posedge clk) begin
      if (reset) begin
         m_busy <= 1'b0; m_done <= 1'b0; m_result <= '0; m_left <= 0;
      end else begin
         m_done <= 1'b0;
         if (m_busy) begin
            if (m_left == 1) begin
               m_busy <= 1'b0; m_done <= 1'b1; m_result <= m_pending; m_left <= 0;
            end else m_left <= m_left - 1;
         end else if (start) begin
            m_busy    <= 1'b1;
            m_left    <= ref_chunks(rs, sgn);
            m_n       <= ref_chunks(rs, sgn);
            m_pending <= ref_result(rm, rs, sgn, accum, acc_in);
            m_op1     <= {sgn & rm[31], rm};
            m_rs      <= rs;
            m_sgn     <= sgn;
         end
      end
   end

   int          kk;
   logic [7:0]  bv;
   logic [9:0]  e_op2;
   logic        e_op2_1;
   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", busy, m_busy);
         chk("done", done, m_done);
         chk("result", result, m_result);
         if (m_busy) begin
            kk    = m_n - m_left;
            bv    = 8'(m_rs >> (8 * kk));
            e_op2 = {(m_sgn ? {2{bv[7]}} : 2'b00), bv};
            e_op2_1 = 1'b0;
            if (kk > 0) e_op2_1 = m_rs[8 * kk - 1];
            chk("op1", op1, m_op1);
            chk("byte_slice", byte_slice, kk);
            chk("msb", msb, m_left == 1);
            chk("op2", op2, e_op2);
            chk("op2_1", op2_1, e_op2_1);
         end else begin
            chk("acc_idle", acc, 0);
            chk("msb_idle", msb, 0);
         end
      end
   end

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic ac, input logic [63:0] ai);
      @(negedge clk);
      rm = a; rs = b; sgn = s; accum = ac; acc_in = ai; start = 1'b1;
      @(negedge clk);
      start = 1'b0; rm = $urandom; rs = $urandom; acc_in = {$urandom, $urandom};
   endtask

   task automatic wait_done(input string name, input int exp_lat, input logic [63:0] exp_res);
      int j = 0;
      while (!done && j < 20) begin
         @(negedge clk);
         j++;
      end
      chk({name, "_latency"}, j, exp_lat);
      chk({name, "_result"}, result, exp_res);
   endtask

   function automatic logic [31:0] gen_rs();
      logic [31:0] v;
      int nb, sh;
      v  = $urandom;
      nb = $urandom_range(1, 4);
      sh = 32 - 8 * nb;
      case ($urandom % 4)
         0: gen_rs = v;
         1: gen_rs = 32'($signed(v << sh) >>> sh);
         2: gen_rs = (v << sh) >> sh;
         default: begin
            case ($urandom % 6)
               0: gen_rs = 32'h0;
               1: gen_rs = 32'hFFFF_FFFF;
               2: gen_rs = 32'h8000_0000;
               3: gen_rs = 32'h7FFF_FFFF;
               4: gen_rs = 32'h0000_0080;
               default: gen_rs = 32'hFFFF_FF80;
            endcase
         end
      endcase
   endfunction

   int busy_cnt, done_cnt;

   initial begin
      reset = 1'b1; start = 1'b0; rm = '0; rs = '0; sgn = 1'b0; accum = 1'b0; acc_in = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      chk("rst_op1", op1, 0);
      chk("rst_op2", op2, 0);
      reset = 1'b0;

      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'h0);
      wait_done("umax", 4, 64'hFFFF_FFFE_0000_0001);
      issue(32'd5, 32'hFFFF_FFFF, 1'b1, 1'b0, 64'h0);
      wait_done("sgn_early", 1, 64'hFFFF_FFFF_FFFF_FFFB);
      issue(32'd2, 32'h0000_1234, 1'b1, 1'b0, 64'h0);
      wait_done("sgn_2chunk", 2, 64'h2468);
      issue(32'd3, 32'd7, 1'b0, 1'b1, 64'd100);
      wait_done("accum", 1, 64'd121);
      issue(32'd1, 32'd1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
      wait_done("accum_wrap", 1, 64'h0);
      issue(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 64'h0);
      wait_done("smin_sq", 4, 64'h4000_0000_0000_0000);
      issue(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, 64'h0);
      wait_done("smax_smin", 4, 64'hC000_0000_8000_0000);
      issue(32'd3, 32'h0000_0080, 1'b0, 1'b0, 64'h0);
      wait_done("u_top_bit", 1, 64'h180);
      issue(32'd3, 32'h0000_0080, 1'b1, 1'b0, 64'h0);
      wait_done("s_top_bit", 2, 64'h180);

      // start held high across a whole op, including the completing edge
      @(negedge clk);
      rm = 32'hFFFF_FFFF; rs = 32'hFFFF_FFFF; sgn = 1'b0; accum = 1'b0; start = 1'b1;
      busy_cnt = 0; done_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         busy_cnt += int'(busy);
         done_cnt += int'(done);
      end
      chk("hs_busy_cycles", busy_cnt, 4);
      chk("hs_done_count", done_cnt, 1);
      chk("hs_result", result, 64'hFFFF_FFFE_0000_0001);
      rm = 32'd2; rs = 32'd3;
      @(negedge clk);
      start = 1'b0;
      chk("hs_accept_after_done", busy, 1);
      wait_done("hs_second", 1, 64'd6);

      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'h0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_result", result, 0);
      chk("abort_acc", acc, 0);
      issue(32'hFFFF_FFFD, 32'd7, 1'b1, 1'b0, 64'h0);
      wait_done("after_abort", 1, 64'hFFFF_FFFF_FFFF_FFEB);

      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         start  = ($urandom % 3) == 0;
         rm     = $urandom;
         rs     = gen_rs();
         sgn    = $urandom % 2;
         accum  = $urandom % 2;
         acc_in = {$urandom, $urandom};
         reset  = ($urandom % 300) == 0;
      end
      @(negedge clk);
      start = 1'b0; reset = 1'b0;
      repeat (8) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
